// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: captures WIDTH bits LSB first after a
// start strobe and presents the word on a one-deep valid/ready output register.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             start,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] dout_nxt;
  logic             dout_valid_nxt;
  logic             overrun_nxt;
  logic             done;

  assign busy = (state == SHIFT);
  assign word = {sin, shreg[WIDTH-1:1]};
  assign done = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    dout_nxt       = dout;
    dout_valid_nxt = dout_valid;
    overrun_nxt    = overrun;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        shreg_nxt = word;
        if (done) begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (clr_overrun)
      overrun_nxt = 1'b0;

    // A finished word may only replace dout if the pending one leaves on this edge.
    if (done) begin
      if (!dout_valid || dout_ready) begin
        dout_nxt       = word;
        dout_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      dout_valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with WIDTH=4; inputs change 1 time unit
// after each rising edge and outputs are sampled there too.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       start = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       dout_ready = 1'b0;
  logic [3:0] dout;
  logic       dout_valid;
  logic       busy;
  logic [1:0] bit_cnt;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  sipo_frame_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .sin(sin), .start(start), .clr_overrun(clr_overrun),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends w[0] first; returns just after the completing edge.
  task automatic send_frame(input logic [3:0] w);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_in_flags got v=%b b=%b o=%b exp 0 0 0", dout_valid, busy, overrun); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (dout !== 4'b0000) begin failures++; $display("FAIL reset_dout got=%b exp=0000", dout); end
    checks++; if (bit_cnt !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_cnt got cnt=%0d busy=%b exp 0 0", bit_cnt, busy); end
    checks++; if (dout_valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_valid got v=%b o=%b exp 0 0", dout_valid, overrun); end
  endtask

  task automatic test_basic_frame();
    logic [3:0] w;
    logic [1:0] exp_cnt;
    w = 4'b1101;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || bit_cnt !== 2'd0) begin failures++; $display("FAIL t1_e0 got busy=%b cnt=%0d exp 1 0", busy, bit_cnt); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL t1_e0_valid got=%b exp=0", dout_valid); end
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      tick();
      exp_cnt = 2'((i + 1) % 4);
      checks++; if (bit_cnt !== exp_cnt || busy !== (i < 3)) begin failures++; $display("FAIL t1_bit%0d got cnt=%0d busy=%b exp cnt=%0d busy=%b", i, bit_cnt, busy, exp_cnt, (i < 3)); end
    end
    checks++; if (dout !== 4'b1101 || dout_valid !== 1'b1) begin failures++; $display("FAIL t1_word got dout=%b v=%b exp 1101 1", dout, dout_valid); end
  endtask

  task automatic test_overrun();
    dout_ready = 1'b0;
    send_frame(4'b0110);
    checks++; if (dout !== 4'b1101 || dout_valid !== 1'b1) begin failures++; $display("FAIL t2_hold got dout=%b v=%b exp 1101 1", dout, dout_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t2_overrun got=%b exp=1", overrun); end
    tick();
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t2_sticky got=%b exp=1", overrun); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t2_clear got=%b exp=0", overrun); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checks++; if (dout_valid !== 1'b0 || dout !== 4'b1101) begin failures++; $display("FAIL t2_consume got v=%b dout=%b exp 0 1101", dout_valid, dout); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    logic [1:0] exp_cnt;
    dout_ready = 1'b1;
    w = 4'b0011;
    start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      start = (i == 1);
      tick();
      exp_cnt = 2'((i + 1) % 4);
      checks++; if (bit_cnt !== exp_cnt) begin failures++; $display("FAIL t3_cnt%0d got=%0d exp=%0d", i, bit_cnt, exp_cnt); end
    end
    start = 1'b0;
    checks++; if (dout !== 4'b0011 || dout_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL t3_first got dout=%b v=%b busy=%b exp 0011 1 0", dout, dout_valid, busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || dout_valid !== 1'b0) begin failures++; $display("FAIL t3_restart got busy=%b v=%b exp 1 0", busy, dout_valid); end
    w = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      tick();
    end
    checks++; if (dout !== 4'b1000 || dout_valid !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL t3_second got dout=%b v=%b o=%b exp 1000 1 0", dout, dout_valid, overrun); end
    tick();
    dout_ready = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL t3_drain got=%b exp=0", dout_valid); end
  endtask

  task automatic test_consume_on_complete();
    logic [3:0] w;
    dout_ready = 1'b0;
    send_frame(4'b1111);
    checks++; if (dout !== 4'b1111 || dout_valid !== 1'b1) begin failures++; $display("FAIL t4_pending got dout=%b v=%b exp 1111 1", dout, dout_valid); end
    w = 4'b0101;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      dout_ready = (i == 3);
      tick();
    end
    dout_ready = 1'b0;
    checks++; if (dout !== 4'b0101 || dout_valid !== 1'b1) begin failures++; $display("FAIL t4_swap got dout=%b v=%b exp 0101 1", dout, dout_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t4_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_async_reset();
    send_frame(4'b0000);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t5_pre_overrun got=%b exp=1", overrun); end
    start = 1'b1;
    tick();
    start = 1'b0;
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bit_cnt !== 2'd0) begin failures++; $display("FAIL t5_async_ctrl got busy=%b cnt=%0d exp 0 0", busy, bit_cnt); end
    checks++; if (dout_valid !== 1'b0 || overrun !== 1'b0 || dout !== 4'b0000) begin failures++; $display("FAIL t5_async_out got v=%b o=%b dout=%b exp 0 0 0000", dout_valid, overrun, dout); end
    #2 rst = 1'b0;
    tick();
    send_frame(4'b0101);
    checks++; if (dout !== 4'b0101 || dout_valid !== 1'b1) begin failures++; $display("FAIL t5_clean got dout=%b v=%b exp 0101 1", dout, dout_valid); end
  endtask

  task automatic test_clear_vs_overrun();
    logic [3:0] w;
    dout_ready = 1'b0;
    send_frame(4'b0011);
    checks++; if (overrun !== 1'b1 || dout !== 4'b0101) begin failures++; $display("FAIL t6_first got o=%b dout=%b exp 1 0101", overrun, dout); end
    w = 4'b1001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = w[i];
      clr_overrun = (i == 3);
      tick();
    end
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL t6_same_edge got=%b exp=1", overrun); end
    checks++; if (dout !== 4'b0101 || dout_valid !== 1'b1) begin failures++; $display("FAIL t6_hold got dout=%b v=%b exp 0101 1", dout, dout_valid); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL t6_clear got=%b exp=0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_back_to_back();
    test_consume_on_complete();
    test_async_reset();
    test_clear_vs_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
